// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, keeps at most one imem request in flight and holds the fetched word for decode.
// Handshake-to-inst_valid is response latency + 1; a decode stall holds the instruction and blocks new requests.
module ifu_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, OUT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_fault_q, inst_fault_d;
  logic [XLEN-1:0] redirect_tgt;
  logic            req_hs;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // Gated by rst so nothing is presented in the reset cycle, whatever state the flops hold.
  assign imem_req_valid = (state_q == REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign inst_valid = (state_q == OUT) && !redirect_valid && !rst;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    unique case (state_q)
      BOOT: begin
        state_d = REQ;
        if (redirect_valid) pc_d = redirect_tgt;
      end
      REQ: begin
        if (req_hs) begin
          state_d = WAIT;
          // Request already went out at the old pc; its response must be thrown away.
          if (redirect_valid) begin
            drop_d = 1'b1;
            pc_d   = redirect_tgt;
          end
        end else if (redirect_valid) begin
          pc_d = redirect_tgt;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
            if (redirect_valid) pc_d = redirect_tgt;
          end else begin
            inst_d       = imem_rsp_data;
            inst_fault_d = imem_rsp_err;
            inst_pc_d    = pc_q;
            state_d      = OUT;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
          pc_d   = redirect_tgt;
        end
      end
      OUT: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage. It owns the PC, issues one instruction-memory request at a time, and captures the response into held instruction/PC registers. It presents the fetched instruction to decode through a valid/ready handshake. It sits directly upstream of the decode-stage pipeline registers and accepts redirects (branch, jump, trap) from execute.

Parameters:
XLEN, 32, width of PC and addresses
ILEN, 32, instruction width
RESET_PC, 32'h8000_0000, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset; synchronous, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  imem accepts request this cycle
imem_req_addr  output  XLEN  fetch address (= pc)
imem_rsp_valid  input  1  response valid (exactly one per accepted request, >=1 cycle later)
imem_rsp_data  input  ILEN  fetched instruction
imem_rsp_err  input  1  access fault for this response
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction
inst  output  ILEN  held instruction
inst_pc  output  XLEN  PC of held instruction
inst_fault  output  1  held instruction had access fault
redirect_valid  input  1  redirect fetch stream
redirect_pc  input  XLEN  redirect target; bits [1:0] are forced to 0 internally

Behaviour:
- States: BOOT, REQ, WAIT, OUT. Registers: state, pc, drop, inst, inst_pc, inst_fault.
- Reset (rst=1 at posedge): state=BOOT, pc=RESET_PC, drop=0, inst=0, inst_pc=0, inst_fault=0.
- During reset and in BOOT, imem_req_valid=0 and inst_valid=0.
- BOOT -> REQ unconditionally on the next cycle. A redirect in BOOT loads pc=redirect_pc.
- imem_req_valid = (state==REQ). imem_req_addr = pc. The address may change while valid; imem samples it only on the handshake cycle.
- REQ:
  - Handshake with no redirect -> WAIT.
  - Handshake with redirect -> WAIT, drop=1, pc=redirect_pc.
  - Redirect with no handshake -> stay in REQ, pc=redirect_pc.
- WAIT:
  - rsp_valid with drop=0 and no redirect: inst=rsp_data, inst_fault=rsp_err, inst_pc=pc, -> OUT.
  - rsp_valid with (drop=1 or redirect): discard the response, drop=0, -> REQ; if redirect, pc=redirect_pc.
  - Redirect with no rsp_valid: drop=1, pc=redirect_pc, stay in WAIT.
- OUT:
  - inst_valid = (state==OUT) && !redirect_valid. This combinational squash path is intentional.
  - inst_ready with no redirect: pc=pc+4, -> REQ.
  - Redirect: pc=redirect_pc, -> REQ; the held instruction is discarded regardless of inst_ready.
  - inst, inst_pc and inst_fault are stable while in OUT.
- Faulting fetch: inst_fault=1, inst=rsp_data as given. It is consumed like a normal instruction and pc advances by 4; decode/execute raise the trap via redirect.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 = 0.
- At most one outstanding imem request at any time. No new request is issued until the outstanding response has returned, including discarded ones.
- Peak throughput is one instruction per 3 cycles (REQ, WAIT, OUT) with single-cycle memory. Latency from request handshake to inst_valid is response latency + 1 cycle.
- Reset asserted mid-operation (any state, outstanding request included) returns to BOOT immediately. Any late response arriving after reset is ignored in BOOT/REQ: rsp_valid outside WAIT is ignored.

Test Plan:
- Reset then free run, imem ready=1, 1-cycle response, inst_ready=1: request addresses 8000_0000, 8000_0004, 8000_0008; inst_pc matches each; inst_valid high every 3rd cycle.
- Decode backpressure: inst_ready=0 for 5 cycles in OUT -> inst/inst_pc/inst_valid held constant, no new imem request; ready=1 -> next request at pc+4.
- Redirect in WAIT to 8000_0100 with 3-cycle response latency -> old response discarded, inst_valid never rises for it; next request address 8000_0100.
- Redirect coinciding with req handshake, then redirect_pc=8000_0203 -> response dropped; next request address 8000_0200 (low bits cleared).
- rsp_err=1 on fetch at 8000_0010 -> inst_valid with inst_fault=1, inst_pc=8000_0010; after consume, next fetch at 8000_0014 with inst_fault=0.
- PC at FFFF_FFFC consumed -> next request address 0000_0000. Reset asserted in WAIT -> req_valid=0 and inst_valid=0 in the reset cycle; first request after release at RESET_PC.
